// File: rtl/voice_allocator_pkg.sv
// Shared voice-allocator configuration, voice/FSM state encodings and the
// note-on/note-off candidate ranking used while scanning voices.
package voice_allocator_pkg;
  localparam int PIPELINE_COUNT = 4;
  localparam int AGE_WIDTH      = 8;
  localparam int NOTE_WIDTH     = 7;
  localparam int PERCENT_WIDTH  = 7;

  typedef logic [NOTE_WIDTH-1:0]    note_t;
  typedef logic [PERCENT_WIDTH-1:0] percent_t;

  typedef enum logic [1:0] {FREE, HELD, RELEASING} voice_state_t;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} ctrl_state_t;

  typedef struct packed {
    logic     on;
    note_t    note;
    percent_t velocity;
  } event_t;

  localparam logic [2:0] RANK_NONE = 3'd4;

  // Lower rank wins; ranks 2 and 3 are further ordered by age (oldest first).
  function automatic logic [2:0] cand_rank(input logic is_on, input voice_state_t st,
                                           input logic note_eq);
    if (is_on) begin
      if (st != FREE && note_eq) return 3'd0;
      if (st == FREE)            return 3'd1;
      if (st == RELEASING)       return 3'd2;
      return 3'd3;
    end
    return (st == HELD && note_eq) ? 3'd0 : RANK_NONE;
  endfunction
endpackage

// File: rtl/voice_allocator_if.sv
// Note event handshake from the MIDI decoder into the voice allocator;
// a transfer happens on a rising edge with event_valid && event_ready.
interface voice_allocator_if;
  import voice_allocator_pkg::*;

  logic     event_valid;
  logic     event_ready;
  logic     event_on;
  note_t    event_note;
  percent_t event_velocity;

  modport master (output event_valid, event_on, event_note, event_velocity,
                  input  event_ready);
  modport slave  (input  event_valid, event_on, event_note, event_velocity,
                  output event_ready);
endinterface

// File: rtl/voice_allocator_slot.sv
// One voice: state, note, velocity, saturating age and sustained flag, with
// registered one-cycle trigger/release pulses. A load always beats voice_done.
module voice_slot
  import voice_allocator_pkg::*;
#(
  parameter int AGE_WIDTH = voice_allocator_pkg::AGE_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  note_t                load_note,
  input  percent_t             load_velocity,
  input  logic                 release_req,
  input  logic                 hold_req,
  input  logic                 sustain_fall,
  input  logic                 age_inc,
  input  logic                 done,
  output voice_state_t         state,
  output note_t                note,
  output percent_t             velocity,
  output logic [AGE_WIDTH-1:0] age,
  output logic                 trigger,
  output logic                 rel_pulse
);
  logic sustained;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= FREE;
      note      <= '0;
      velocity  <= '0;
      age       <= '0;
      sustained <= 1'b0;
      trigger   <= 1'b0;
      rel_pulse <= 1'b0;
    end else begin
      trigger   <= load;
      rel_pulse <= 1'b0;
      if (load) begin
        state     <= HELD;
        note      <= load_note;
        velocity  <= load_velocity;
        age       <= '0;
        sustained <= 1'b0;
      end else begin
        if (age_inc && state != FREE && age != '1)
          age <= age + 1'b1;
        if (release_req && state == HELD) begin
          state     <= RELEASING;
          rel_pulse <= 1'b1;
          sustained <= 1'b0;
        end else if (hold_req && state == HELD) begin
          sustained <= 1'b1;
        end else if (sustain_fall && sustained && state == HELD) begin
          state     <= RELEASING;
          rel_pulse <= 1'b1;
          sustained <= 1'b0;
        end else if (done && state == RELEASING) begin
          state <= FREE;
        end
      end
    end
  end
endmodule

// File: rtl/voice_allocator.sv
// Allocates note events to VOICES voices (retrigger, free, oldest releasing, oldest held);
// VOICES+2 cycles per event, ready low while busy. Sustain pedal: VOICE_ALLOCATOR_SUSTAIN_EN.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int VOICES    = PIPELINE_COUNT,
  parameter int AGE_WIDTH = voice_allocator_pkg::AGE_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  voice_allocator_if.slave      ev,
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
  input  logic                  sustain,
`endif
  input  logic [VOICES-1:0]     voice_done,
  output logic [VOICES-1:0]     voice_active,
  output note_t    [VOICES-1:0] voice_note,
  output percent_t [VOICES-1:0] voice_velocity,
  output logic [VOICES-1:0]     voice_trigger,
  output logic [VOICES-1:0]     voice_release
);
  localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;

  ctrl_state_t          state_q, state_d;
  event_t               ev_q;
  logic [IW-1:0]        scan_idx, best_idx;
  logic [2:0]           best_rank, cur_rank;
  logic [AGE_WIDTH-1:0] best_age;
  voice_state_t         slot_state [VOICES];
  logic [AGE_WIDTH-1:0] slot_age   [VOICES];
  logic                 take, commit, hit, sus_level, sus_fall;

  assign ev.event_ready = (state_q == IDLE);
  assign commit         = (state_q == COMMIT);
  assign hit            = (best_rank != RANK_NONE);
  assign cur_rank       = cand_rank(ev_q.on, slot_state[scan_idx],
                                    voice_note[scan_idx] == ev_q.note);
  // Strict compares keep the lowest index on rank and age ties.
  assign take = (cur_rank < best_rank) ||
                (cur_rank == best_rank && cur_rank inside {3'd2, 3'd3} &&
                 slot_age[scan_idx] > best_age);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ev.event_valid) state_d = SCAN;
      SCAN:    if (scan_idx == IW'(VOICES - 1)) state_d = COMMIT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ev_q      <= '0;
      scan_idx  <= '0;
      best_idx  <= '0;
      best_rank <= RANK_NONE;
      best_age  <= '0;
    end else if (state_q == IDLE) begin
      if (ev.event_valid) begin
        ev_q      <= '{on: ev.event_on && (ev.event_velocity != '0),
                       note: ev.event_note, velocity: ev.event_velocity};
        scan_idx  <= '0;
        best_idx  <= '0;
        best_rank <= RANK_NONE;
        best_age  <= '0;
      end
    end else if (state_q == SCAN) begin
      scan_idx <= scan_idx + 1'b1;
      if (take) begin
        best_idx  <= scan_idx;
        best_rank <= cur_rank;
        best_age  <= slot_age[scan_idx];
      end
    end
  end

`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
  logic sus_q, sus_q2;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sus_q  <= 1'b0;
      sus_q2 <= 1'b0;
    end else begin
      sus_q  <= sustain;
      sus_q2 <= sus_q;
    end
  end
  assign sus_level = sus_q;
  assign sus_fall  = sus_q2 & ~sus_q;
`else
  assign sus_level = 1'b0;
  assign sus_fall  = 1'b0;
`endif

  for (genvar i = 0; i < VOICES; i++) begin : g_slot
    logic sel;
    assign sel = commit && hit && (best_idx == IW'(i));

    voice_slot #(.AGE_WIDTH(AGE_WIDTH)) u_slot (
      .clock         (clock),
      .reset         (reset),
      .load          (sel && ev_q.on),
      .load_note     (ev_q.note),
      .load_velocity (ev_q.velocity),
      .release_req   (sel && !ev_q.on && !sus_level),
      .hold_req      (sel && !ev_q.on && sus_level),
      .sustain_fall  (sus_fall),
      .age_inc       (commit && ev_q.on),
      .done          (voice_done[i]),
      .state         (slot_state[i]),
      .note          (voice_note[i]),
      .velocity      (voice_velocity[i]),
      .age           (slot_age[i]),
      .trigger       (voice_trigger[i]),
      .rel_pulse     (voice_release[i])
    );

    assign voice_active[i] = (slot_state[i] != FREE);
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Randomized scoreboard bench for voice_allocator against an array-based allocation model.
module tb_voice_allocator;
  import voice_allocator_pkg::*;

  localparam int NV   = 4;
  localparam int AW   = 3;
  localparam int AMAX = 7;

  logic clock = 1'b0;
  logic reset;
  logic [NV-1:0]      voice_done;
  logic [NV-1:0]      voice_active, voice_trigger, voice_release;
  logic [NV-1:0][6:0] voice_note, voice_velocity;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
  logic sustain;
`endif

  voice_allocator_if ev ();

  voice_allocator #(.VOICES(NV), .AGE_WIDTH(AW)) dut (
    .clock          (clock),
    .reset          (reset),
    .ev             (ev),
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    .sustain        (sustain),
`endif
    .voice_done     (voice_done),
    .voice_active   (voice_active),
    .voice_note     (voice_note),
    .voice_velocity (voice_velocity),
    .voice_trigger  (voice_trigger),
    .voice_release  (voice_release)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  trig, rel, active;
    logic [27:0] notes, vels;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: 0 = free, 1 = held, 2 = releasing.
  int mst[NV], mnote[NV], mvel[NV], mage[NV];
  bit msus[NV];
  bit sus_lvl = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      mst[i] = 0; mnote[i] = 0; mvel[i] = 0; mage[i] = 0; msus[i] = 1'b0;
    end
  endtask

  function automatic int oldest(input int st);
    int best = -1;
    for (int i = 0; i < NV; i++)
      if (mst[i] == st && (best < 0 || mage[i] > mage[best])) best = i;
    return best;
  endfunction

  task automatic model_event(input bit on, input int note, input int vel, output int tgt,
                             output int prior, output logic [3:0] trig, output logic [3:0] rel);
    tgt = -1; prior = 0; trig = '0; rel = '0;
    if (on && vel != 0) begin
      for (int i = 0; i < NV; i++) if (tgt < 0 && mst[i] != 0 && mnote[i] == note) tgt = i;
      for (int i = 0; i < NV; i++) if (tgt < 0 && mst[i] == 0) tgt = i;
      if (tgt < 0) tgt = oldest(2);
      if (tgt < 0) tgt = oldest(1);
      prior = mst[tgt];
      for (int i = 0; i < NV; i++)
        if (i != tgt && mst[i] != 0) mage[i] = (mage[i] < AMAX) ? mage[i] + 1 : AMAX;
      mst[tgt] = 1; mnote[tgt] = note; mvel[tgt] = vel; mage[tgt] = 0; msus[tgt] = 1'b0;
      trig[tgt] = 1'b1;
    end else begin
      for (int i = 0; i < NV; i++) if (tgt < 0 && mst[i] == 1 && mnote[i] == note) tgt = i;
      if (tgt >= 0) begin
        prior = 1;
        if (sus_lvl) msus[tgt] = 1'b1;
        else begin
          mst[tgt] = 2; msus[tgt] = 1'b0; rel[tgt] = 1'b1;
        end
      end
    end
  endtask

  function automatic exp_t snapshot(input logic [3:0] trig, input logic [3:0] rel);
    exp_t e;
    e.trig = trig; e.rel = rel; e.active = '0; e.notes = '0; e.vels = '0;
    for (int i = 0; i < NV; i++) begin
      e.active[i]      = (mst[i] != 0);
      e.notes[i*7 +: 7] = 7'(mnote[i]);
      e.vels[i*7 +: 7]  = 7'(mvel[i]);
    end
    return e;
  endfunction

  // Monitor: an event completes when event_ready rises again.
  int   cyc = 0, acc_cyc = 0;
  logic ready_prev = 1'b1;
  bit   abort_pending = 1'b0, allow_stray = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (ev.event_ready && !ready_prev) begin
      if (abort_pending) abort_pending = 1'b0;
      else if (exp_q.size() == 0) chk("unexpected_completion", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("latency", cyc - acc_cyc, NV + 2);
        chk("trigger", {28'd0, voice_trigger}, {28'd0, mon_e.trig});
        chk("release", {28'd0, voice_release}, {28'd0, mon_e.rel});
        chk("active", {28'd0, voice_active}, {28'd0, mon_e.active});
        chk("notes", {4'd0, voice_note}, {4'd0, mon_e.notes});
        chk("velocities", {4'd0, voice_velocity}, {4'd0, mon_e.vels});
      end
    end else if (!allow_stray) begin
      chk("stray_pulse", {24'd0, voice_trigger, voice_release}, 32'd0);
    end
    if (ev.event_valid && ev.event_ready) acc_cyc = cyc;
    ready_prev = ev.event_ready;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ev.event_ready && n < 20) begin
      step();
      n++;
    end
    if (!ev.event_ready) chk(name, 32'd0, 32'd1);
  endtask

  task automatic pulse_done(input logic [3:0] mask);
    voice_done = mask;
    step();
    voice_done = '0;
    for (int i = 0; i < NV; i++) if (mask[i] && mst[i] == 2) mst[i] = 0;
  endtask

  task automatic send_event(input bit on, input int note, input int vel, input bit done_at_commit);
    int tgt, prior;
    logic [3:0] trig, rel;
    wait_ready("ready_before_event");
    model_event(on, note, vel, tgt, prior, trig, rel);
    exp_q.push_back(snapshot(trig, rel));
    ev.event_valid    = 1'b1;
    ev.event_on       = on;
    ev.event_note     = 7'(note);
    ev.event_velocity = 7'(vel);
    step();
    ev.event_valid = 1'b0;
    if (done_at_commit && trig != 0 && prior == 2) begin
      repeat (NV) step();
      voice_done = 4'(1 << tgt);
      step();
      voice_done = '0;
    end
    wait_ready("ready_after_event");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [3:0] seen, want;
    reset = 1'b1;
    voice_done = '0;
    ev.event_valid = 1'b0; ev.event_on = 1'b0; ev.event_note = '0; ev.event_velocity = '0;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    sustain = 1'b0;
`endif
    model_reset();
    repeat (3) step();
    reset = 1'b0;
    step();

    chk("reset_ready", {31'd0, ev.event_ready}, 32'd1);
    chk("reset_active", {28'd0, voice_active}, 32'd0);
    chk("reset_notes", {4'd0, voice_note}, 32'd0);
    chk("reset_vels", {4'd0, voice_velocity}, 32'd0);
    chk("reset_pulses", {24'd0, voice_trigger, voice_release}, 32'd0);

    send_event(1, 60, 100, 0);
    chk("first_note_v0", {25'd0, voice_note[0]}, 32'd60);
    chk("first_vel_v0", {25'd0, voice_velocity[0]}, 32'd100);
    send_event(1, 62, 80, 0);
    send_event(1, 64, 70, 0);
    send_event(1, 65, 60, 0);
    send_event(1, 67, 50, 0);
    chk("steal_note_v0", {25'd0, voice_note[0]}, 32'd67);

    send_event(0, 67, 0, 0);
    pulse_done(4'b0001);
    chk("done_frees_v0", {31'd0, voice_active[0]}, 32'd0);

    send_event(1, 60, 90, 0);
    send_event(0, 64, 40, 0);
    send_event(1, 70, 30, 0);
    chk("releasing_preferred_v2", {25'd0, voice_note[2]}, 32'd70);

    send_event(1, 60, 0, 0);
    chk("vel0_is_noteoff", {31'd0, voice_active[0]}, 32'd1);
    send_event(0, 61, 10, 0);
    send_event(1, 60, 55, 1);
    chk("commit_beats_done", {31'd0, voice_active[0]}, 32'd1);
    pulse_done(4'b1111);
    chk("done_on_held_ignored", {28'd0, voice_active}, 32'hf);

    ev.event_valid = 1'b1; ev.event_on = 1'b1; ev.event_note = 7'd99; ev.event_velocity = 7'd9;
    step();
    ev.event_valid = 1'b0;
    step();
    abort_pending = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    step();
    chk("abort_active", {28'd0, voice_active}, 32'd0);
    chk("abort_pulses", {24'd0, voice_trigger, voice_release}, 32'd0);
    chk("abort_ready", {31'd0, ev.event_ready}, 32'd1);

`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    sustain = 1'b1; sus_lvl = 1'b1;
    step(); step();
    send_event(1, 60, 90, 0);
    send_event(1, 72, 90, 0);
    send_event(0, 60, 0, 0);
    want = '0;
    for (int i = 0; i < NV; i++) if (mst[i] == 1 && msus[i]) want[i] = 1'b1;
    allow_stray = 1'b1;
    sustain = 1'b0; sus_lvl = 1'b0;
    cnt = 0; seen = '0;
    repeat (6) begin
      step();
      cnt += $countones(voice_release);
      seen |= voice_release;
    end
    allow_stray = 1'b0;
    for (int i = 0; i < NV; i++) if (want[i]) begin mst[i] = 2; msus[i] = 1'b0; end
    chk("sustain_release_mask", {28'd0, seen}, {28'd0, want});
    chk("sustain_release_count", cnt, $countones(want));
    chk("sustain_target_v0", {28'd0, want}, 32'd1);
`endif

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 2) == 0) pulse_done(4'($urandom));
      send_event($urandom_range(0, 9) < 6, 60 + $urandom_range(0, 7),
                 ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127),
                 bit'($urandom_range(0, 1)));
    end

    step(); step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Assigns incoming note-on/note-off events to the `PIPELINE_COUNT` synthesis pipelines. It tracks each voice's state, note, velocity and age, and steals the oldest voice when all are busy. It drives per-voice trigger/release pulses into the envelope generators. It sits between the MIDI decoder and the pipeline array, in the system clock domain.

## Interface
- `VOICES`, default `CONFIG::PIPELINE_COUNT` (4): number of voices managed.
- `AGE_WIDTH`, default `CONFIG::AGE_WIDTH` (8): saturating age counter width.
- `clock`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `event_valid`  in  1  event present.
- `event_ready`  out  1  allocator can accept an event; a transfer occurs when valid && ready on a rising edge.
- `event_on`  in  1  1 = note-on, 0 = note-off.
- `event_note`  in  7  MIDI note number.
- `event_velocity`  in  `PERCENT_WIDTH`  velocity; a note-on with velocity 0 is treated as a note-off.
- `voice_done`  in  `VOICES`  per-voice envelope finished its release.
- `voice_active`  out  `VOICES`  voice is HELD or RELEASING.
- `voice_note`  out  `VOICES`×7  note assigned to each voice.
- `voice_velocity`  out  `VOICES`×`PERCENT_WIDTH`  velocity assigned to each voice.
- `voice_trigger`  out  `VOICES`  one-cycle pulse to (re)start a voice's envelope.
- `voice_release`  out  `VOICES`  one-cycle pulse to enter release.

## Operation
- Per-voice state: FREE, HELD, RELEASING.
- Control FSM: IDLE → SCAN → COMMIT → IDLE.
- IDLE: `event_ready`=1. On transfer, latch the event, clear the scan index and go to SCAN.
- SCAN: examines one voice per cycle (index 0..VOICES-1) and keeps the best candidate.
- Note-on candidate priority:
  - (1) voice HELD/RELEASING with the same note (retrigger);
  - (2) lowest-index FREE voice;
  - (3) oldest RELEASING voice;
  - (4) oldest HELD voice.
  - Age ties resolve to the lowest index.
- Note-off: the candidate is the HELD voice with the matching note. With no match, the event is consumed with no effect.
- COMMIT, note-on:
  - target voice → HELD, note and velocity loaded, age ← 0, `voice_trigger[i]` pulses.
  - All other active voices age += 1, saturating at 2^AGE_WIDTH−1.
  - A stolen voice gets a trigger only, never a release pulse.
- COMMIT, note-off: target voice → RELEASING, `voice_release[i]` pulses.
- RELEASING → FREE on `voice_done[i]`=1, in any FSM state. `voice_done` on a HELD or FREE voice is ignored.
- If `voice_done[i]` arrives in the same cycle as a COMMIT targeting voice i, the COMMIT wins.
- `voice_note` and `voice_velocity` hold their last values after a voice returns to FREE.

## Timing
- Event accepted at edge k: SCAN occupies cycles k+1..k+VOICES, COMMIT is cycle k+VOICES+1.
- Pulses and state changes are visible from k+VOICES+2, and `event_ready` returns high in that same cycle.
- Throughput: one event per VOICES+2 cycles (6 cycles at 4 voices, far above the MIDI rate).
- `event_ready` is low throughout SCAN and COMMIT.
- Every pulse output is exactly one cycle wide and registered.
- Reset values: all voices FREE, `voice_active`=0, notes=0, velocities=0, ages=0, pulses=0, FSM=IDLE, `event_ready`=1.
- Reset asserted mid-SCAN aborts the event with no pulse emitted.

## Configuration
- `VOICE_ALLOCATOR_SUSTAIN_EN` defined:
  - Adds input port `sustain` (1 bit).
  - A note-off while `sustain`=1 sets the voice's sustained flag and leaves it HELD, with no release pulse.
  - On a registered falling edge of `sustain`, every sustained HELD voice → RELEASING with `voice_release` pulsed, and the flags clear.
  - A note-on retrigger of a sustained voice clears its flag.
- Undefined: there is no `sustain` port and every note-off releases immediately.

## Structure
- Added to `CONFIG`:
  - `NOTE_WIDTH`=7 and `note_t`;
  - `AGE_WIDTH`=8;
  - enum `voice_state_t` {FREE, HELD, RELEASING}.
- Sub-module `voice_slot` holds one voice's state, note, velocity, age and sustained flag. It is instantiated VOICES times. The FSM and candidate selection stay in `voice_allocator`.

## Test plan
- Reset, then note-on 60 vel 100 → ready low for 5 cycles; `voice_trigger[0]` pulses in cycle 6; voice 0 HELD with note 60, vel 100.
- Note-ons 60, 62, 64, 65, then 67 → 67 steals voice 0 (oldest); trigger[0] pulses with no release[0]; `voice_note[0]`=67.
- Note-on 60, note-off 60 → release[0] pulses and voice 0 is RELEASING; `voice_done[0]`=1 for 1 cycle → `voice_active[0]`=0 next cycle.
- Voices 0 and 1 HELD, voice 2 RELEASING, voice 3 HELD; a new note-on → voice 2 is chosen ahead of the older HELD voices.
- Note-on 60 vel 0 → handled as a note-off; note-off 61 with no voice holding 61 → no pulses, ready returns after 6 cycles.
- With `VOICE_ALLOCATOR_SUSTAIN_EN`: sustain=1, note-off 60 → no release; sustain 1→0 → release[0] pulses once.
